// File: rtl/fifo_pkg.sv
// Shared constants and pointer comparison helper for the fifo_sync family.
package fifo_pkg;

    localparam int FIFO_STD  = 32'sd0;
    localparam int FIFO_FWFT = 32'sd1;

    typedef struct packed {
        logic full;
        logic empty;
    } ptr_flags_t;

    // Pointers carry one wrap bit above the aw address bits.
    function automatic ptr_flags_t ptr_cmp(input logic [31:0] wr_ptr,
                                           input logic [31:0] rd_ptr,
                                           input int          aw);
        logic [31:0] mask_s;
        logic [31:0] diff_s;
        ptr_flags_t  res_s;
        mask_s       = (32'd1 << (aw + 32'sd1)) - 32'd1;
        diff_s       = (wr_ptr ^ rd_ptr) & mask_s;
        res_s.full   = (diff_s == (32'd1 << aw));
        res_s.empty  = (diff_s == 32'd0);
        return res_s;
    endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// Simple dual-port RAM for fifo_sync: synchronous write, registered read.
module fifo_sync_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = 32'sd8,
    parameter int ADDR_W = 32'sd4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_en,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_data
);

    localparam int DEPTH = 32'sd1 << ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] r_data_r;

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_en) begin
            mem_r[w_addr] <= w_data;
        end
    end

    // Read output register, cleared so r_data is defined after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_r <= {DATA_W{1'b0}};
        end else if (r_en) begin
            r_data_r <= mem_r[r_addr];
        end
    end

    assign r_data = r_data_r;

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO: pointers, count, flags and error pulses around fifo_sync_mem,
// with an optional first-word-fall-through prefetch stage.
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 32'sd8,
    parameter int ADDR_W    = 32'sd4,
    parameter int AFULL_TH  = 32'sd12,
    parameter int AEMPTY_TH = 32'sd4,
    parameter int FWFT      = 32'sd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_en,
    output logic [DATA_W-1:0] r_data,
    output logic              w_full,
    output logic              r_empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH    = 32'sd1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C  = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] AFULL_C  = AFULL_TH[ADDR_W:0];
    localparam logic [ADDR_W:0] AEMPTY_C = AEMPTY_TH[ADDR_W:0];
    localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    generate
        if (AFULL_TH < 32'sd1 || AFULL_TH > DEPTH) begin : g_bad_afull
            $error("fifo_sync: AFULL_TH must lie in 1..DEPTH");
        end
        if (AEMPTY_TH < 32'sd0 || AEMPTY_TH >= DEPTH) begin : g_bad_aempty
            $error("fifo_sync: AEMPTY_TH must lie in 0..DEPTH-1");
        end
    endgenerate

    logic [ADDR_W:0] wr_ptr_r, rd_ptr_r, count_r;
    logic            valid_r, mem_empty_r;
    logic            w_full_r, r_empty_r, afull_r, aempty_r, ovf_r, unf_r;

    logic            wr_acc_s, rd_acc_s, mem_rd_s, valid_nxt_s;
    logic            full_nxt_s, empty_nxt_s;
    logic [ADDR_W:0] wr_ptr_nxt_s, rd_ptr_nxt_s, count_nxt_s;
    ptr_flags_t      flags_nxt_s;

    // Request qualification, prefetch decision and post-edge count/flags.
    always_comb begin
        wr_acc_s     = w_en && !w_full_r;
        rd_acc_s     = r_en && !r_empty_r;
        mem_rd_s     = 1'b0;
        valid_nxt_s  = 1'b0;
        if (FWFT == FIFO_FWFT) begin
            // The RAM output register is the prefetch stage; refill it when it empties or is consumed.
            mem_rd_s = !mem_empty_r && (!valid_r || rd_acc_s);
            if (mem_rd_s) begin
                valid_nxt_s = 1'b1;
            end else if (rd_acc_s) begin
                valid_nxt_s = 1'b0;
            end else begin
                valid_nxt_s = valid_r;
            end
        end else begin
            mem_rd_s    = rd_acc_s;
            valid_nxt_s = 1'b0;
        end
        wr_ptr_nxt_s = wr_acc_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
        rd_ptr_nxt_s = mem_rd_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        count_nxt_s  = (wr_ptr_nxt_s - rd_ptr_nxt_s) + {{ADDR_W{1'b0}}, valid_nxt_s};
        flags_nxt_s  = ptr_cmp(32'(wr_ptr_nxt_s), 32'(rd_ptr_nxt_s), ADDR_W);
        if (FWFT == FIFO_FWFT) begin
            full_nxt_s  = (count_nxt_s == DEPTH_C);
            empty_nxt_s = !valid_nxt_s;
        end else begin
            full_nxt_s  = flags_nxt_s.full;
            empty_nxt_s = flags_nxt_s.empty;
        end
    end

    // Pointer, count, flag and error-pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r    <= {(ADDR_W+1){1'b0}};
            rd_ptr_r    <= {(ADDR_W+1){1'b0}};
            count_r     <= {(ADDR_W+1){1'b0}};
            valid_r     <= 1'b0;
            mem_empty_r <= 1'b1;
            w_full_r    <= 1'b0;
            r_empty_r   <= 1'b1;
            afull_r     <= 1'b0;
            aempty_r    <= 1'b1;
            ovf_r       <= 1'b0;
            unf_r       <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            valid_r     <= valid_nxt_s;
            mem_empty_r <= flags_nxt_s.empty;
            w_full_r    <= full_nxt_s;
            r_empty_r   <= empty_nxt_s;
            afull_r     <= (count_nxt_s >= AFULL_C);
            aempty_r    <= (count_nxt_s <= AEMPTY_C);
            ovf_r       <= w_en && w_full_r;
            unf_r       <= r_en && r_empty_r;
        end
    end

    fifo_sync_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk    (clk),
        .rst    (rst),
        .w_en   (wr_acc_s),
        .w_addr (wr_ptr_r[ADDR_W-1:0]),
        .w_data (w_data),
        .r_en   (mem_rd_s),
        .r_addr (rd_ptr_r[ADDR_W-1:0]),
        .r_data (r_data)
    );

    assign w_full       = w_full_r;
    assign r_empty      = r_empty_r;
    assign almost_full  = afull_r;
    assign almost_empty = aempty_r;
    assign count        = count_r;
    assign overflow     = ovf_r;
    assign underflow    = unf_r;

endmodule

// File: tb/tb_fifo_sync.sv
// Self-checking bench for fifo_sync: directed vector table, queue-model random run,
// FWFT latency sequence and mid-stream reset.
module tb_fifo_sync;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       w_en = 1'b0, r_en = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic [7:0] r_data;
    logic [4:0] count;
    logic       w_full, r_empty, almost_full, almost_empty, overflow, underflow;

    logic       w_en_f = 1'b0, r_en_f = 1'b0;
    logic [7:0] w_data_f = 8'h00;
    logic [7:0] r_data_f;
    logic [4:0] count_f;
    logic       w_full_f, r_empty_f, almost_full_f, almost_empty_f, overflow_f, underflow_f;

    always #5 clk = ~clk;

    fifo_sync #(.DATA_W(8), .ADDR_W(4), .AFULL_TH(12), .AEMPTY_TH(4), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .w_en(w_en), .w_data(w_data), .r_en(r_en), .r_data(r_data),
        .w_full(w_full), .r_empty(r_empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
    );

    fifo_sync #(.DATA_W(8), .ADDR_W(4), .AFULL_TH(12), .AEMPTY_TH(4), .FWFT(1)) dut_f (
        .clk(clk), .rst(rst), .w_en(w_en_f), .w_data(w_data_f), .r_en(r_en_f), .r_data(r_data_f),
        .w_full(w_full_f), .r_empty(r_empty_f), .almost_full(almost_full_f),
        .almost_empty(almost_empty_f), .count(count_f), .overflow(overflow_f), .underflow(underflow_f)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       w;
        logic [7:0] d;
        logic       r;
        int         cnt;
        logic       full, empty, af, ae, ovf, unf;
        logic [7:0] rd;
    } vec_t;

    vec_t tbl[$];

    // Flags follow from the count alone: full at 16, empty at 0, thresholds 12 and 4.
    function automatic vec_t mkc(input logic w, input logic [7:0] d, input logic r, input int cnt,
                                 input logic ovf, input logic unf, input logic [7:0] rd);
        vec_t v;
        v.w = w; v.d = d; v.r = r; v.cnt = cnt;
        v.full = (cnt == DEPTH); v.empty = (cnt == 0);
        v.af = (cnt >= 12); v.ae = (cnt <= 4);
        v.ovf = ovf; v.unf = unf; v.rd = rd;
        return v;
    endfunction

    logic [7:0] mq[$];
    logic [7:0] m_rd = 8'h00;

    // One clock on the standard-mode FIFO, checked against the queue model.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input string tag);
        logic m_full, m_empty, m_ovf, m_unf;
        m_full  = (mq.size() == DEPTH);
        m_empty = (mq.size() == 0);
        m_ovf   = w && m_full;
        m_unf   = r && m_empty;
        if (r && !m_empty) m_rd = mq.pop_front();
        if (w && !m_full) mq.push_back(d);
        w_en = w; w_data = d; r_en = r;
        @(posedge clk); #1;
        check({tag, ".count"}, 32'(count), 32'(mq.size()));
        check({tag, ".w_full"}, 32'(w_full), 32'(mq.size() == DEPTH));
        check({tag, ".r_empty"}, 32'(r_empty), 32'(mq.size() == 0));
        check({tag, ".almost_full"}, 32'(almost_full), 32'(mq.size() >= 12));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(mq.size() <= 4));
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
        check({tag, ".r_data"}, 32'(r_data), 32'(m_rd));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        w_en = 1'b0; r_en = 1'b0; w_en_f = 1'b0; r_en_f = 1'b0;
        mq.delete();
        m_rd = 8'h00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b1;
        #1;
        check("rst.count", 32'(count), 32'd0);
        check("rst.r_empty", 32'(r_empty), 32'd1);
        check("rst.almost_empty", 32'(almost_empty), 32'd1);
        check("rst.w_full", 32'(w_full), 32'd0);
        check("rst.almost_full", 32'(almost_full), 32'd0);
        check("rst.overflow", 32'(overflow), 32'd0);
        check("rst.underflow", 32'(underflow), 32'd0);
        check("rst.r_data", 32'(r_data), 32'd0);
        check("rst.fwft_r_empty", 32'(r_empty_f), 32'd1);
        check("rst.fwft_count", 32'(count_f), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed table: fill, overflow on full, drain, underflow cases.
        for (int i = 0; i < 16; i++) tbl.push_back(mkc(1'b1, 8'(i), 1'b0, i + 1, 1'b0, 1'b0, 8'h00));
        tbl.push_back(mkc(1'b1, 8'hEE, 1'b1, 15, 1'b1, 1'b0, 8'h00));
        tbl.push_back(mkc(1'b0, 8'h00, 1'b0, 15, 1'b0, 1'b0, 8'h00));
        for (int k = 1; k < 16; k++) tbl.push_back(mkc(1'b0, 8'h00, 1'b1, 15 - k, 1'b0, 1'b0, 8'(k)));
        tbl.push_back(mkc(1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 8'h0F));
        tbl.push_back(mkc(1'b1, 8'h5A, 1'b1, 1, 1'b0, 1'b1, 8'h0F));
        tbl.push_back(mkc(1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0, 8'h0F));
        tbl.push_back(mkc(1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0, 8'h5A));

        for (int i = 0; i < tbl.size(); i++) begin
            w_en = tbl[i].w; w_data = tbl[i].d; r_en = tbl[i].r;
            @(posedge clk); #1;
            check($sformatf("tbl%0d.count", i), 32'(count), 32'(tbl[i].cnt));
            check($sformatf("tbl%0d.w_full", i), 32'(w_full), 32'(tbl[i].full));
            check($sformatf("tbl%0d.r_empty", i), 32'(r_empty), 32'(tbl[i].empty));
            check($sformatf("tbl%0d.almost_full", i), 32'(almost_full), 32'(tbl[i].af));
            check($sformatf("tbl%0d.almost_empty", i), 32'(almost_empty), 32'(tbl[i].ae));
            check($sformatf("tbl%0d.overflow", i), 32'(overflow), 32'(tbl[i].ovf));
            check($sformatf("tbl%0d.underflow", i), 32'(underflow), 32'(tbl[i].unf));
            check($sformatf("tbl%0d.r_data", i), 32'(r_data), 32'(tbl[i].rd));
        end

        // Steady streaming at count 8 across several pointer wraps.
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, "prefill");
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 8'(i + 8'h20), 1'b1, "stream");
            check("stream.count8", 32'(count), 32'd8);
        end
        for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1, "drain");

        // Random traffic with write-heavy, read-heavy and balanced phases.
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 150; i++) begin
                int wp;
                wp = (ph == 0) ? 75 : ((ph == 1) ? 25 : 50);
                cyc(($urandom_range(0, 99) < wp), 8'($urandom), ($urandom_range(0, 99) < (100 - wp)), "rand");
            end
        end

        // FWFT: prefetch latency and consecutive reads.
        do_reset();
        w_en_f = 1'b1; w_data_f = 8'hA5;
        @(posedge clk); #1;
        w_en_f = 1'b0;
        check("fwft.empty_after_write", 32'(r_empty_f), 32'd1);
        check("fwft.count_after_write", 32'(count_f), 32'd1);
        check("fwft.w_full", 32'(w_full_f), 32'd0);
        check("fwft.almost_full", 32'(almost_full_f), 32'd0);
        check("fwft.almost_empty", 32'(almost_empty_f), 32'd1);
        @(posedge clk); #1;
        check("fwft.empty_second_edge", 32'(r_empty_f), 32'd0);
        check("fwft.r_data_second_edge", 32'(r_data_f), 32'hA5);
        r_en_f = 1'b1;
        @(posedge clk); #1;
        r_en_f = 1'b0;
        check("fwft.empty_after_read", 32'(r_empty_f), 32'd1);
        check("fwft.count_after_read", 32'(count_f), 32'd0);
        check("fwft.overflow", 32'(overflow_f), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            w_en_f = 1'b1; w_data_f = 8'(8'h11 * i);
            @(posedge clk); #1;
        end
        w_en_f = 1'b0;
        @(posedge clk); #1;
        check("fwft.head", 32'(r_data_f), 32'h11);
        check("fwft.count3", 32'(count_f), 32'd3);
        for (int i = 2; i <= 4; i++) begin
            r_en_f = 1'b1;
            @(posedge clk); #1;
            check($sformatf("fwft.count_rd%0d", i), 32'(count_f), 32'(4 - i));
            check($sformatf("fwft.empty_rd%0d", i), 32'(r_empty_f), 32'(i == 4));
            if (i < 4) check($sformatf("fwft.data_rd%0d", i), 32'(r_data_f), 32'(8'h11 * i));
            else check("fwft.data_hold", 32'(r_data_f), 32'h33);
        end
        @(posedge clk); #1;
        r_en_f = 1'b0;
        check("fwft.underflow", 32'(underflow_f), 32'd1);

        // Asynchronous reset in the middle of a write burst.
        do_reset();
        for (int i = 0; i < 9; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, "burst");
        w_en = 1'b1; w_data = 8'h49;
        #2 rst = 1'b1;
        #1;
        check("midrst.count", 32'(count), 32'd0);
        check("midrst.r_empty", 32'(r_empty), 32'd1);
        check("midrst.r_data", 32'(r_data), 32'd0);
        check("midrst.w_full", 32'(w_full), 32'd0);
        do_reset();
        cyc(1'b1, 8'hC3, 1'b0, "post_rst_wr");
        cyc(1'b0, 8'h00, 1'b1, "post_rst_rd");
        cyc(1'b0, 8'h00, 1'b1, "post_rst_unf");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
